icache_ctrl_v2: RTL and testbench

- Instruction-cache controller sitting directly upstream of the direct-mapped cache line BRAM (1024 lines × 512 bits, 17-bit tag word per line).
- Accepts fetch requests from the fetch stage and performs hit lookup against the BRAM's combinational read port.
- On miss, fetches the 64-byte line from memory as 16 × 32-bit beats, writes the line and tag into the BRAM, then returns the requested word.
- Also provides a whole-cache invalidate sweep.

---
 rtl/icache_pkg.sv | 44 ++++
 rtl/line_fill_buf.sv | 32 +++
 rtl/icache_ctrl_v2.sv | 157 +++++++++++++++
 tb/tb_icache_ctrl_v2.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, FSM state encoding and address-field helpers for the icache controller.
package icache_pkg;

   localparam int unsigned INDEX_W    = 10;
   localparam int unsigned TAG_W      = 16;
   localparam int unsigned LINE_WORDS = 16;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned LINE_BITS  = LINE_WORDS * WORD_W;
   localparam int unsigned BEAT_W     = 4;
   localparam int unsigned OFFS_W     = 6;
   localparam int unsigned LINES      = 1 << INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MREQ,
      FILL,
      WRITE,
      FLUSH
   } state_t;

   // Tag word as stored alongside each BRAM line.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } tag_word_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[31 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return addr[OFFS_W +: INDEX_W];
   endfunction

   function automatic logic [BEAT_W-1:0] addr_word(input logic [31:0] addr);
      return addr[2 +: BEAT_W];
   endfunction

   function automatic logic [31:0] line_base(input logic [31:0] addr);
      return {addr[31:OFFS_W], OFFS_W'(0)};
   endfunction

endpackage

// File: rtl/line_fill_buf.sv
// Shift-in buffer assembling one cache line from 16 sequential 32-bit memory beats.
module line_fill_buf
   import icache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 beat_valid,
   input  logic [WORD_W-1:0]    beat_data,
   output logic [LINE_BITS-1:0] line,
   output logic                 done_c
);

   logic [BEAT_W-1:0]    count_q;
   logic [LINE_BITS-1:0] line_q;

   // Final beat is being accepted this cycle.
   assign done_c = beat_valid && (count_q == BEAT_W'(LINE_WORDS - 1));
   assign line   = line_q;

   // Beat k lands in word slot k; clear restarts the count and zeroes the line.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count_q <= '0;
         line_q  <= '0;
      end else if (beat_valid) begin
         line_q[{count_q, 5'b0} +: WORD_W] <= beat_data;
         count_q                           <= count_q + BEAT_W'(1);
      end
   end

endmodule

// File: rtl/icache_ctrl_v2.sv
// Direct-mapped instruction cache controller: hit lookup, line refill and invalidate sweep.
module icache_ctrl_v2
   import icache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inst_req,
   input  logic [31:0]          inst_addr,
   output logic                 inst_ready,
   output logic [31:0]          inst_rdata,
   input  logic                 inv_req,
   output logic                 inv_done,
   output logic                 mem_req,
   output logic [31:0]          mem_addr,
   input  logic                 mem_ack,
   input  logic                 mem_rvalid,
   input  logic [31:0]          mem_rdata,
   output logic                 bram_we,
   output logic [INDEX_W-1:0]   bram_addr,
   output logic [TAG_W:0]       bram_tag_in,
   output logic [LINE_BITS-1:0] bram_data_in,
   input  logic [TAG_W:0]       bram_tag_out,
   input  logic [LINE_BITS-1:0] bram_data_out
);

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d;
   logic [INDEX_W-1:0] sweep_q, sweep_d;
   logic               mem_req_q, mem_req_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic               bram_we_q, bram_we_d;
   logic [INDEX_W-1:0] bram_addr_q, bram_addr_d;
   tag_word_t          tag_in_q, tag_in_d;
   logic               inv_done_q, inv_done_d;
   logic               fill_clear, fill_en, fill_done_c;
   logic               hit_c;

   line_fill_buf u_fill (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (fill_clear),
      .beat_valid (fill_en),
      .beat_data  (mem_rdata),
      .line       (bram_data_in),
      .done_c     (fill_done_c)
   );

   // Hit decode off the BRAM's combinational read; the answer must leave in the LOOKUP cycle itself.
   assign hit_c = (state_q == LOOKUP) && bram_tag_out[TAG_W]
                  && (bram_tag_out[TAG_W-1:0] == addr_tag(a_q));

   assign inst_ready  = hit_c;
   assign inst_rdata  = hit_c ? bram_data_out[{addr_word(a_q), 5'b0} +: WORD_W] : 32'h0;
   assign inv_done    = inv_done_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign bram_we     = bram_we_q;
   assign bram_addr   = bram_addr_q;
   assign bram_tag_in = tag_in_q;

   // Next state plus next values of the registered outputs, keyed on the state being entered.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      sweep_d     = sweep_q;
      mem_req_d   = 1'b0;
      mem_addr_d  = 32'h0;
      bram_we_d   = 1'b0;
      bram_addr_d = '0;
      tag_in_d    = '0;
      inv_done_d  = 1'b0;
      fill_clear  = 1'b0;
      fill_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (inv_req) begin
               state_d    = FLUSH;
               sweep_d    = '0;
               fill_clear = 1'b1;
               bram_we_d  = 1'b1;
            end else if (inst_req) begin
               state_d     = LOOKUP;
               a_d         = inst_addr;
               bram_addr_d = addr_index(inst_addr);
            end
         end
         LOOKUP: begin
            if (hit_c) begin
               state_d = IDLE;
            end else begin
               state_d    = MREQ;
               mem_req_d  = 1'b1;
               mem_addr_d = line_base(a_q);
            end
         end
         MREQ: begin
            if (mem_ack) begin
               state_d    = FILL;
               fill_clear = 1'b1;
            end else begin
               mem_req_d  = 1'b1;
               mem_addr_d = line_base(a_q);
            end
         end
         FILL: begin
            fill_en = mem_rvalid;
            if (fill_done_c) begin
               state_d     = WRITE;
               bram_we_d   = 1'b1;
               bram_addr_d = addr_index(a_q);
               tag_in_d    = '{valid: 1'b1, tag: addr_tag(a_q)};
            end
         end
         WRITE: begin
            state_d     = LOOKUP;
            bram_addr_d = addr_index(a_q);
         end
         FLUSH: begin
            if (sweep_q == INDEX_W'(LINES - 1)) begin
               state_d    = IDLE;
               inv_done_d = 1'b1;
            end else begin
               sweep_d     = sweep_q + INDEX_W'(1);
               bram_we_d   = 1'b1;
               bram_addr_d = sweep_q + INDEX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any fill in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= 32'h0;
         sweep_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'h0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         tag_in_q    <= '0;
         inv_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         sweep_q     <= sweep_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         tag_in_q    <= tag_in_d;
         inv_done_q  <= inv_done_d;
      end
   end

endmodule

// File: tb/tb_icache_ctrl_v2.sv
// Scoreboard bench for icache_ctrl_v2 with a BRAM model, inline memory responder and reference cache.
`timescale 1ns/1ps
module tb_icache_ctrl_v2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         inst_req;
   logic [31:0]  inst_addr;
   logic         inst_ready;
   logic [31:0]  inst_rdata;
   logic         inv_req;
   logic         inv_done;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         bram_we;
   logic [9:0]   bram_addr;
   logic [16:0]  bram_tag_in;
   logic [511:0] bram_data_in;
   logic [16:0]  bram_tag_out;
   logic [511:0] bram_data_out;

   icache_ctrl_v2 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_ready    (inst_ready),
      .inst_rdata    (inst_rdata),
      .inv_req       (inv_req),
      .inv_done      (inv_done),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .bram_we       (bram_we),
      .bram_addr     (bram_addr),
      .bram_tag_in   (bram_tag_in),
      .bram_data_in  (bram_data_in),
      .bram_tag_out  (bram_tag_out),
      .bram_data_out (bram_data_out)
   );

   always #5 clk = ~clk;

   // BRAM model: synchronous write, combinational read.
   bit [16:0]  tag_mem  [1024];
   bit [511:0] data_mem [1024];
   assign bram_tag_out  = tag_mem[bram_addr];
   assign bram_data_out = data_mem[bram_addr];
   always @(posedge clk) begin
      if (bram_we) begin
         tag_mem[bram_addr]  <= bram_tag_in;
         data_mem[bram_addr] <= bram_data_in;
      end
   end

   int cyc_now = 0;
   always @(posedge clk) cyc_now <= cyc_now + 1;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        miss;
   } exp_t;
   typedef struct packed {
      logic [9:0]   idx;
      logic [16:0]  tag;
      logic [511:0] line;
   } wr_t;
   exp_t exp_q[$];
   wr_t  wr_q[$];

   // Reference cache: valid bit and tag per line index.
   bit        ref_v [1024];
   bit [15:0] ref_t [1024];

   // Backing memory image: the test line at 0x1040 holds 0x100..0x10F, everything else is hashed.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if ((w >> 6) == (32'h0000_1040 >> 6)) return 32'h100 + ((w >> 2) & 32'hF);
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, {55'h0, inst_ready, inv_done, mem_req, bram_we, |inst_rdata, |mem_addr,
                 |bram_addr, |bram_tag_in, |bram_data_in}, 64'h0);
   endtask

   // Monitor: pops expectations whenever the DUT presents a word or a BRAM write.
   int mreq_cnt  = 0;
   bit mreq_prev = 0;
   int flush_idx = 0;
   initial begin
      exp_t e;
      wr_t  w;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mreq_cnt  = 0;
            mreq_prev = 0;
         end else begin
            if (mem_req && !mreq_prev) mreq_cnt++;
            mreq_prev = mem_req;
            if (inst_ready) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL ready_unexpected: rdata %h with no request outstanding", inst_rdata);
               end else begin
                  e = exp_q.pop_front();
                  if (inst_rdata !== e.rdata || (mreq_cnt != 0) != e.miss) begin
                     errors++;
                     $display("FAIL fetch_result: rdata %h miss %0d, required rdata %h miss %0d",
                              inst_rdata, mreq_cnt != 0, e.rdata, e.miss);
                  end
               end
               mreq_cnt = 0;
            end else if (inst_rdata !== 32'h0) begin
               errors++;
               $display("FAIL rdata_idle: got %h, required 0", inst_rdata);
            end
            if (bram_we && bram_tag_in[16]) begin
               vectors++;
               if (wr_q.size() == 0) begin
                  errors++;
                  $display("FAIL write_unexpected: idx %h tag %h", bram_addr, bram_tag_in);
               end else begin
                  w = wr_q.pop_front();
                  if (bram_addr !== w.idx || bram_tag_in !== w.tag || bram_data_in !== w.line) begin
                     errors++;
                     $display("FAIL fill_write: idx %h tag %h, required idx %h tag %h, line_ok %0d",
                              bram_addr, bram_tag_in, w.idx, w.tag, bram_data_in === w.line);
                  end
               end
            end else if (bram_we) begin
               if (bram_addr !== 10'(flush_idx) || bram_tag_in !== 17'h0 || bram_data_in !== '0) begin
                  errors++;
                  $display("FAIL flush_write: idx %h tag %h, required idx %h tag 0 data 0",
                           bram_addr, bram_tag_in, 10'(flush_idx));
               end
               flush_idx++;
            end
            if (inv_done) begin
               chk("flush_count", 64'(flush_idx), 64'd1024);
               flush_idx = 0;
            end
         end
      end
   end

   // One fetch, with the memory side served inline. gap_mode: 0 none, 1 two idle cycles between beats, 2 random.
   task automatic fetch(input logic [31:0] addr, input int gap_mode, input bit abort);
      int           idx, start, d, gaps, g;
      logic [15:0]  tg;
      bit           exp_miss, done, served, aborted;
      logic [511:0] line;
      idx      = int'((addr >> 6) & 32'h3FF);
      tg       = addr[31:16];
      exp_miss = !(ref_v[idx] && ref_t[idx] == tg);
      for (int k = 0; k < 16; k++)
         line[32*k +: 32] = mem_word((addr & 32'hFFFF_FFC0) | 32'(k << 2));
      if (!abort) begin
         exp_q.push_back('{rdata: mem_word(addr), miss: exp_miss});
         if (exp_miss) begin
            wr_q.push_back('{idx: 10'(idx), tag: {1'b1, tg}, line: line});
            ref_v[idx] = 1'b1;
            ref_t[idx] = tg;
         end
      end
      inst_req  = 1'b1;
      inst_addr = addr;
      start     = cyc_now;
      d = 0; gaps = 0; done = 0; served = 0; aborted = 0;
      while (!done) begin
         @(posedge clk); #1;
         if (cyc_now - start > 400) begin
            errors++;
            $display("FAIL fetch_timeout: addr %h got no inst_ready, required one", addr);
            inst_req = 1'b0;
            done     = 1;
         end else if (inst_ready) begin
            chk("latency", 64'(cyc_now - start), exp_miss ? 64'(20 + d + gaps) : 64'd1);
            inst_req = 1'b0;
            done     = 1;
            @(posedge clk); #1;
         end else if (mem_req && !served) begin
            served = 1;
            chk("mem_addr", 64'(mem_addr), 64'(addr & 32'hFFFF_FFC0));
            d = $urandom_range(0, 2);
            repeat (d) begin @(posedge clk); #1; end
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk("mem_req_drop", 64'(mem_req), 64'd0);
            for (int k = 0; k < 16; k++) begin
               g = (gap_mode == 1) ? ((k == 0) ? 0 : 2) :
                   (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
               mem_rvalid = 1'b0;
               mem_rdata  = $urandom;
               repeat (g) begin @(posedge clk); #1; end
               gaps += g;
               mem_rvalid = 1'b1;
               mem_rdata  = line[32*k +: 32];
               @(posedge clk); #1;
               if (abort && k == 7) begin
                  aborted = 1;
                  break;
               end
            end
            mem_rvalid = 1'b0;
            if (aborted) begin
               rst_n      = 1'b0;
               inst_req   = 1'b0;
               mem_rvalid = 1'b1;
               mem_rdata  = line[32*8 +: 32];
               @(posedge clk); #1;
               chk_outs_zero("abort_reset_outs");
               rst_n = 1'b1;
               for (int k = 9; k < 16; k++) begin
                  mem_rdata = line[32*k +: 32];
                  @(posedge clk); #1;
               end
               mem_rvalid = 1'b0;
               repeat (3) begin @(posedge clk); #1; end
               chk("abort_no_write", 64'(wr_q.size()), 64'd0);
               done = 1;
            end
         end
      end
   endtask

   task automatic flush();
      int start;
      bit done;
      start   = cyc_now;
      done    = 0;
      inv_req = 1'b1;
      @(posedge clk); #1;
      inv_req = 1'b0;
      while (!done) begin
         if (inv_done) begin
            chk("flush_latency", 64'(cyc_now - start), 64'd1025);
            done = 1;
         end else if (cyc_now - start > 1200) begin
            errors++;
            $display("FAIL flush_timeout: no inv_done, required one");
            done = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      for (int i = 0; i < 1024; i++) ref_v[i] = 1'b0;
   endtask

   initial begin
      logic [15:0] tags [3];
      logic [9:0]  idxs [6];
      logic [31:0] a;
      tags[0] = 16'h0000; tags[1] = 16'h0001; tags[2] = 16'h00A5;
      for (int i = 0; i < 6; i++) idxs[i] = 10'($urandom);
      inst_req = 0; inst_addr = 0; inv_req = 0;
      mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_outs_zero("reset_outs");
      rst_n = 1'b1;
      @(posedge clk); #1;

      fetch(32'h0000_1040, 1, 0);
      fetch(32'h0000_107C, 0, 0);
      fetch(32'h0001_1040, 2, 0);
      fetch(32'h0000_1040, 0, 0);
      fetch(32'h0000_1048, 0, 0);
      flush();
      fetch(32'h0000_1040, 2, 0);
      fetch(32'h0003_2080, 2, 1);
      fetch(32'h0003_2080, 0, 0);
      fetch(32'h0003_2086, 0, 0);

      for (int n = 0; n < 250; n++) begin
         if (n == 100 || n == 200) flush();
         a = {tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 5)], 4'($urandom), 2'($urandom)};
         fetch(a, 2, 0);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("queues_drained", 64'(exp_q.size() + wr_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
